// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Fallback keeps the package self-contained when no global width macro is supplied.
`ifndef PROGRAM_MEMORY_ADDRESS_BITWIDTH
`define PROGRAM_MEMORY_ADDRESS_BITWIDTH 16
`endif

package program_loader_pkg;

    typedef enum logic [2:0] {IDLE, HEADER, DATA, DONE, ERROR} loader_state_t;

    localparam int HEADER_BYTES = 4;

    function automatic logic is_loading(input loader_state_t s);
        return (s == HEADER) || (s == DATA);
    endfunction

endpackage

// File: rtl/byte_assembler.sv
// Little-endian byte-to-word packer: out_valid pulses combinationally on the 4th byte,
// with out_word carrying the three stored bytes plus the byte arriving now.
module byte_assembler
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        out_valid,
    output logic [31:0] out_word
);

    localparam logic [1:0] LAST_IDX = 2'(HEADER_BYTES - 1);

    logic [1:0]  idx_q, idx_d;
    logic [23:0] low_q, low_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        idx_d = idx_q;
        low_d = low_q;
        if (clear) begin
            idx_d = '0;
            low_d = '0;
        end else if (in_valid) begin
            idx_d = idx_q + 2'd1;
            case (idx_q)
                2'd0:    low_d[7:0]   = in_byte;
                2'd1:    low_d[15:8]  = in_byte;
                2'd2:    low_d[23:16] = in_byte;
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q <= '0;
            low_q <= '0;
        end else begin
            idx_q <= idx_d;
            low_q <= low_d;
        end
    end

    assign out_valid = in_valid && (idx_q == LAST_IDX);
    assign out_word  = {in_byte, low_q};

endmodule

// File: rtl/program_loader.sv
// Parses a word-count header and streams little-endian words into program memory;
// busy/done/error report progress, and all outputs are registered.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_BW = `PROGRAM_MEMORY_ADDRESS_BITWIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               rx_valid,
    input  logic [7:0]         rx_data,
    output logic               we,
    output logic [ADDR_BW-1:0] waddr,
    output logic [31:0]        wdata,
    output logic               busy,
    output logic               done,
    output logic               error
);

    // One extra counter bit so a count equal to CAPACITY is representable.
    localparam int          CW       = ADDR_BW - 1;
    localparam logic [31:0] CAPACITY = 32'(1) << (ADDR_BW - 2);

    loader_state_t      state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [CW-1:0]      word_idx_q, word_idx_d;
    logic               we_q, we_d;
    logic [ADDR_BW-1:0] waddr_q, waddr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               loading;
    logic               start_ok;
    logic               asm_valid;
    logic [31:0]        asm_word;

    assign loading  = is_loading(state_q);
    assign start_ok = start && !loading;

    byte_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (start_ok),
        .in_valid  (rx_valid && loading),
        .in_byte   (rx_data),
        .out_valid (asm_valid),
        .out_word  (asm_word)
    );

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        word_idx_d = word_idx_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;

        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (start_ok) begin
                    state_d    = HEADER;
                    count_d    = '0;
                    word_idx_d = '0;
                end
            end
            HEADER: begin
                // Full 32-bit compare: a large count must not alias to a small one.
                if (asm_valid) begin
                    if (asm_word == 32'd0) begin
                        state_d = DONE;
                    end else if (asm_word > CAPACITY) begin
                        state_d = ERROR;
                    end else begin
                        state_d = DATA;
                        count_d = asm_word[CW-1:0];
                    end
                end
            end
            DATA: begin
                if (asm_valid) begin
                    we_d       = 1'b1;
                    waddr_d    = {word_idx_q[ADDR_BW-3:0], 2'b00};
                    wdata_d    = asm_word;
                    word_idx_d = word_idx_q + CW'(1);
                    if (word_idx_d == count_q) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d  = is_loading(state_d);
        done_d  = (state_d == DONE);
        error_d = (state_d == ERROR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            word_idx_q <= word_idx_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign we    = we_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a 6-bit address (16-word capacity);
// a negedge monitor logs every write strobe for comparison against hand-computed lists.
module tb_program_loader;

    localparam int ADDR_BW = 6;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               rx_valid;
    logic [7:0]         rx_data;
    logic               we;
    logic [ADDR_BW-1:0] waddr;
    logic [31:0]        wdata;
    logic               busy;
    logic               done;
    logic               error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [ADDR_BW-1:0] mon_addr[$];
    logic [31:0]        mon_data[$];
    logic               mon_done[$];
    logic               mon_busy[$];
    logic [ADDR_BW-1:0] exp_addr[$];
    logic [31:0]        exp_data[$];

    program_loader #(.ADDR_BW(ADDR_BW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we) begin
            mon_addr.push_back(waddr);
            mon_data.push_back(wdata);
            mon_done.push_back(done);
            mon_busy.push_back(busy);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        mon_addr.delete();
        mon_data.delete();
        mon_done.delete();
        mon_busy.delete();
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic expect_write(input logic [ADDR_BW-1:0] a, input logic [31:0] d);
        exp_addr.push_back(a);
        exp_data.push_back(d);
    endtask

    task automatic verify_writes(input string tag);
        int n;
        check($sformatf("%s_count", tag), 64'(mon_addr.size()), 64'(exp_addr.size()));
        n = (mon_addr.size() < exp_addr.size()) ? mon_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), 64'(mon_addr[i]), 64'(exp_addr[i]));
            check($sformatf("%s_data%0d", tag, i), 64'(mon_data[i]), 64'(exp_data[i]));
        end
    endtask

    task automatic idle_cycles(input int n);
        rx_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        idle_cycles(gap);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) begin
            send_byte(w[8*k +: 8], gap);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    function automatic logic [63:0] outs();
        return 64'({we, waddr, wdata, busy, done, error});
    endfunction

    initial begin
        logic [31:0] words3 [3];
        words3[0] = 32'hDEADBEEF;
        words3[1] = 32'h01234567;
        words3[2] = 32'hA5A55A5A;

        reset    = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", outs(), 64'd0);
        reset = 1'b0;
        idle_cycles(1);

        // Bytes before start are ignored.
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        send_byte(8'h03, 0);
        send_byte(8'h04, 0);
        idle_cycles(2);
        check("idle_ignores_rx", outs(), 64'd0);
        check("idle_no_we", 64'(mon_addr.size()), 64'd0);

        // Basic two-word load, back-to-back bytes.
        clear_logs();
        pulse_start();
        check("busy_after_start", 64'(busy), 64'd1);
        send_word(32'h00000002, 0);
        send_word(32'h00000013, 0);
        send_word(32'h00100093, 0);
        expect_write(6'h00, 32'h00000013);
        expect_write(6'h04, 32'h00100093);
        idle_cycles(3);
        verify_writes("two_word");
        if (mon_done.size() == 2) begin
            check("two_word_w0_busy", 64'(mon_busy[0]), 64'd1);
            check("two_word_w0_done", 64'(mon_done[0]), 64'd0);
            check("two_word_w1_busy", 64'(mon_busy[1]), 64'd0);
            check("two_word_w1_done", 64'(mon_done[1]), 64'd1);
        end
        check("two_word_final_flags", 64'({busy, done, error}), 64'b010);

        // Zero header with a coincident start on the 4th byte: start is ignored.
        clear_logs();
        pulse_start();
        check("zero_done_cleared", 64'({busy, done, error}), 64'b100);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        rx_valid = 1'b1;
        rx_data  = 8'h00;
        start    = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        start    = 1'b0;
        check("zero_done_next_cycle", 64'({busy, done, error}), 64'b010);
        idle_cycles(3);
        check("zero_stays_done", 64'({busy, done, error}), 64'b010);
        check("zero_no_we", 64'(mon_addr.size()), 64'd0);

        // Oversize header (CAPACITY+1 = 17).
        clear_logs();
        pulse_start();
        send_word(32'h00000011, 0);
        check("oversize_error", 64'({busy, done, error}), 64'b001);
        idle_cycles(2);
        check("oversize_no_we", 64'(mon_addr.size()), 64'd0);

        // Upper header bits alone must still be rejected, not truncated to zero.
        pulse_start();
        send_word(32'h00010000, 0);
        check("upper_bits_error", 64'({busy, done, error}), 64'b001);

        // Recovery after error: normal one-word load.
        clear_logs();
        pulse_start();
        send_word(32'h00000001, 0);
        send_word(32'hCAFEF00D, 0);
        expect_write(6'h00, 32'hCAFEF00D);
        idle_cycles(2);
        verify_writes("after_error");
        check("after_error_done", 64'({busy, done, error}), 64'b010);

        // Three words with 1-3 idle cycles between bytes.
        clear_logs();
        pulse_start();
        send_word(32'h00000003, 2);
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < 4; k++) begin
                send_byte(words3[i][8*k +: 8], ((i + k) % 3) + 1);
            end
        end
        expect_write(6'h00, 32'hDEADBEEF);
        expect_write(6'h04, 32'h01234567);
        expect_write(6'h08, 32'hA5A55A5A);
        idle_cycles(2);
        verify_writes("gapped");

        // Same three words back-to-back.
        clear_logs();
        pulse_start();
        send_word(32'h00000003, 0);
        for (int i = 0; i < 3; i++) send_word(words3[i], 0);
        expect_write(6'h00, 32'hDEADBEEF);
        expect_write(6'h04, 32'h01234567);
        expect_write(6'h08, 32'hA5A55A5A);
        idle_cycles(2);
        verify_writes("b2b");

        // Reset after 2 of 4 bytes of word 1.
        clear_logs();
        pulse_start();
        send_word(32'h00000002, 0);
        send_word(32'h11111111, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        reset = 1'b1;
        #1;
        check("midload_reset_outputs", outs(), 64'd0);
        idle_cycles(1);
        reset = 1'b0;
        idle_cycles(1);
        clear_logs();
        pulse_start();
        send_word(32'h00000001, 0);
        send_word(32'h11223344, 0);
        expect_write(6'h00, 32'h11223344);
        idle_cycles(2);
        verify_writes("post_reset");

        // Count = CAPACITY (16): last write at 2^6-4 = 60, no wrap afterwards.
        clear_logs();
        pulse_start();
        send_word(32'h00000010, 0);
        for (int i = 0; i < 16; i++) begin
            send_word(32'hC0DE0000 | 32'(i), 0);
            expect_write(6'(4 * i), 32'hC0DE0000 | 32'(i));
        end
        idle_cycles(2);
        check("capacity_done", 64'({busy, done, error}), 64'b010);
        send_word(32'h55555555, 0);
        idle_cycles(2);
        verify_writes("capacity");
        if (mon_done.size() == 16) begin
            check("capacity_last_done", 64'(mon_done[15]), 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
